// File: rtl/collatz.sv
// rtl/collatz.sv - handshaked 16-bit Collatz step counter
//
// Purpose:
//   Accepts a signed start value n and returns the number of Collatz steps
//   needed to reach 1. One step is computed per clock cycle. A start value
//   <= 1 (signed) returns 0 without stepping. Arithmetic wraps modulo 2^16,
//   including the 3n+1 product and the step counter.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   in0 carries a start value
//   in_ready   out  1   block can accept a start value (high only in IDLE)
//   in0        in   16  start value n (signed)
//   out_valid  out  1   out0 carries a completed result (high only in DONE)
//   out_ready  in   1   downstream accepts the result
//   out0       out  16  step count; held after the handshake until rewritten

module collatz #(
  parameter int INT_N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_N-1:0] in0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_N-1:0] out0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [INT_N-1:0] r_n;
  logic [INT_N-1:0] r_cnt;
  logic [INT_N-1:0] r_out0;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_finished;
  logic [INT_N-1:0] w_step;
  logic [INT_N-1:0] w_triple_plus_one;

  // Termination uses a signed compare so that 0 and negative values, which
  // can also appear after a 3n+1 wrap, stop immediately.
  assign w_finished = ($signed(r_n) <= $signed(INT_N'(1)));

  // 3n+1 built as (n<<1)+n+1; the result is truncated to INT_N bits, which is
  // the intended modulo-2^INT_N wrap.
  assign w_triple_plus_one = (r_n << 1) + r_n + INT_N'(1);

  // Even values shift right logically; odd values take 3n+1.
  assign w_step = r_n[0] ? w_triple_plus_one : (r_n >> 1);

  // Handshake flags are registered alongside the state so that they depend
  // on the state register only, never combinationally on the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_cnt       <= '0;
      r_out0      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_n         <= in0;
            r_cnt       <= '0;
            r_state     <= S_RUN;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end

        S_RUN: begin
          if (w_finished) begin
            r_out0      <= r_cnt;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_n   <= w_step;
            r_cnt <= r_cnt + INT_N'(1);
          end
        end

        S_DONE: begin
          // Leaving DONE on the handshake edge makes in_ready return the
          // very next cycle; with out_ready tied high out_valid is a pulse.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out0      = r_out0;

endmodule

// File: tb/tb_collatz.sv
// tb/tb_collatz.sv - directed table-driven bench for collatz
module tb_collatz;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out0;

  int checks = 0;
  int errors = 0;

  collatz dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    int          steps;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a start value and let it be accepted on the next rising edge.
  task automatic accept(input logic [15:0] n, input logic drop_valid);
    in0      = n;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    if (drop_valid) in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
  endtask

  // Cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    int k;

    vecs[0] = '{16'd27,    111};
    vecs[1] = '{16'd1,     0};
    vecs[2] = '{16'd0,     0};
    vecs[3] = '{16'hFFFB,  0};   // -5
    vecs[4] = '{16'd2,     1};
    vecs[5] = '{16'd6,     8};
    vecs[6] = '{16'd7,     16};
    vecs[7] = '{16'd3,     7};
    vecs[8] = '{16'd9,     19};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in0       = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out0", out0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].n, 1'b1);
      wait_valid(k);
      check($sformatf("latency_%0d", vecs[i].n), k, vecs[i].steps + 1);
      check($sformatf("result_%0d", vecs[i].n), out0, vecs[i].steps);
      @(posedge clk);
      #1;
      check("pulse_end", out_valid, 0);
      check("in_ready_back", in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      check("out0_held", out0, vecs[i].steps);
    end

    // Backpressure: result and valid held while out_ready is low.
    out_ready = 1'b0;
    accept(16'd3, 1'b1);
    wait_valid(k);
    check("bp_latency", k, 8);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      check("bp_valid_held", out_valid, 1);
      check("bp_out0_held", out0, 7);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);

    // in_valid held with changing in0 during RUN must be ignored.
    accept(16'd7, 1'b0);
    k = 0;
    while (!out_valid && k < 200) begin
      in0 = 16'($urandom_range(2, 60000));
      @(posedge clk);
      #1;
      k++;
    end
    in_valid = 1'b0;
    check("ignore_latency", k, 17);
    check("ignore_result", out0, 16);
    @(posedge clk);
    #1;
    check("ignore_in_ready", in_ready, 1);
    check("ignore_no_restart", out_valid, 0);

    // Reset mid-RUN aborts; a fresh run afterwards works.
    accept(16'd27, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out0", out0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    accept(16'd6, 1'b1);
    wait_valid(k);
    check("postrst_latency", k, 9);
    check("postrst_result", out0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
